// File: rtl/mul_div_unit_pkg.sv
// ============================================================================
// Module  : mul_div_unit_pkg
// Purpose : Shared definitions for the iterative multiply/divide unit:
//           operation encoding, FSM state encoding, iteration count and
//           small two's-complement helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_div_unit_pkg;

  // Operation select encoding as seen on the op input
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Number of datapath steps; one operand bit is retired per step
  localparam int ITER_COUNT = 32;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Two's-complement negation of a 32-bit word
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of a signed 32-bit word; 32'h80000000 maps to itself, which
  // is the correct unsigned magnitude 2^31
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module  : mul_div_unit
// Purpose : Iterative signed 32x32 multiplier (radix-2 Booth) and signed
//           32/32 divider (non-restoring on magnitudes). Both algorithms
//           share one 65-bit accumulator/shift register and one 33-bit
//           adder/subtractor. Result appears 34 cycles after start is
//           accepted; one operation can be accepted every 35 cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // Accumulator layout depends on the operation:
  //   MUL: acc[64:33] = partial product high word A
  //        acc[32:1]  = multiplier / product low word Q
  //        acc[0]     = Booth look-behind bit q(-1)
  //   DIV: acc[64:32] = signed 33-bit partial remainder R
  //        acc[31:0]  = dividend magnitude shifting out / quotient shifting in
  state_t      state;
  logic [5:0]  count;
  logic [64:0] acc;
  logic [31:0] m_reg;     // MUL: multiplicand; DIV: divisor magnitude
  logic [31:0] a_reg;     // original dividend, for signs and div-by-zero result
  logic        op_reg;
  logic        b_neg;     // divisor was negative
  logic        zero_div;  // captured divisor was zero

  // --------------------------------------------------------------------------
  // Shared 33-bit adder/subtractor
  // --------------------------------------------------------------------------
  logic [32:0] add_x;
  logic [32:0] add_y;
  logic        add_sub;
  logic [32:0] add_sum;

  // Select adder operands for the current step: Booth add/sub of the
  // multiplicand, non-restoring add/sub of the divisor, or the final
  // remainder restore in FIX
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_sub = 1'b0;
    case (state)
      ST_ITER: begin
        if (op_reg == OP_MUL) begin
          // Sign-extend A so that A - (-2^31) cannot overflow
          add_x   = {acc[64], acc[64:33]};
          add_y   = {m_reg[31], m_reg};
          add_sub = (acc[1:0] == 2'b10);
        end else begin
          // Partial remainder after the left shift: {R[31:0], Q[31]}
          add_x   = acc[63:31];
          add_y   = {1'b0, m_reg};
          add_sub = ~acc[64];
        end
      end
      ST_FIX: begin
        add_x   = acc[64:32];
        add_y   = {1'b0, m_reg};
        add_sub = 1'b0;
      end
      default: begin
        add_x   = '0;
        add_y   = '0;
        add_sub = 1'b0;
      end
    endcase
  end

  // One adder: subtraction is addition of the inverted operand plus one
  assign add_sum = add_x + (add_y ^ {33{add_sub}}) + {32'd0, add_sub};

  // --------------------------------------------------------------------------
  // Next accumulator value for one ITER step
  // --------------------------------------------------------------------------
  logic [32:0] booth_mid;
  logic [64:0] iter_next;

  // Booth: optionally add/sub, then arithmetic shift right of {A,Q,q-1}.
  // The 33-bit sum shifted right always fits the 32-bit A field.
  // Non-restoring: shift left, add/sub, quotient bit = sign of new R inverted.
  always_comb begin
    booth_mid = (acc[1] ^ acc[0]) ? add_sum : {acc[64], acc[64:33]};
    if (op_reg == OP_MUL) begin
      iter_next = {booth_mid, acc[32:1]};
    end else begin
      iter_next = {add_sum, acc[30:0], ~add_sum[32]};
    end
  end

  // --------------------------------------------------------------------------
  // Final result formation in FIX
  // --------------------------------------------------------------------------
  logic [31:0] rem_mag;
  logic [31:0] quo_mag;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;
  logic        fix_div0;

  // Restore a negative remainder, apply signs, and override for /0
  always_comb begin
    rem_mag  = acc[64] ? add_sum[31:0] : acc[63:32];
    quo_mag  = acc[31:0];
    fix_div0 = 1'b0;
    if (op_reg == OP_MUL) begin
      fix_hi = acc[64:33];
      fix_lo = acc[32:1];
    end else if (zero_div) begin
      fix_hi   = a_reg;
      fix_lo   = 32'hFFFF_FFFF;
      fix_div0 = 1'b1;
    end else begin
      // Quotient negative when operand signs differ; remainder follows the
      // dividend. 0x80000000 / -1 yields magnitude 2^31 with a positive
      // sign, whose 32-bit pattern is 0x80000000.
      fix_lo = (a_reg[31] ^ b_neg) ? neg32(quo_mag) : quo_mag;
      fix_hi = a_reg[31] ? neg32(rem_mag) : rem_mag;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer, datapath registers and registered outputs
  // --------------------------------------------------------------------------
  // IDLE captures operands on start, ITER runs 32 steps, FIX loads the
  // result, DONE returns to IDLE and raises the one-cycle done pulse.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      acc      <= '0;
      m_reg    <= '0;
      a_reg    <= '0;
      op_reg   <= OP_MUL;
      b_neg    <= 1'b0;
      zero_div <= 1'b0;
      z_hi     <= '0;
      z_lo     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div0     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= ST_ITER;
            busy     <= 1'b1;
            count    <= '0;
            div0     <= 1'b0;
            op_reg   <= op;
            a_reg    <= a_in;
            b_neg    <= b_in[31];
            zero_div <= (op == OP_DIV) && (b_in == '0);
            if (op == OP_MUL) begin
              m_reg <= a_in;
              acc   <= {32'd0, b_in, 1'b0};
            end else begin
              m_reg <= abs32(b_in);
              acc   <= {33'd0, abs32(a_in)};
            end
          end
        end

        ST_ITER: begin
          acc <= iter_next;
          if (count == 6'(ITER_COUNT - 1)) begin
            count <= '0;
            state <= ST_FIX;
          end else begin
            count <= count + 6'd1;
          end
        end

        ST_FIX: begin
          z_hi  <= fix_hi;
          z_lo  <= fix_lo;
          div0  <= fix_div0;
          state <= ST_DONE;
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module  : tb_mul_div_unit
// Purpose : Self-checking bench for mul_div_unit with directed corner cases
//           and randomized back-to-back operations against an arithmetic
//           reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

  logic        clk   = 1'b0;
  logic        clr_n = 1'b1;
  logic        start = 1'b0;
  logic        op    = 1'b0;
  logic [31:0] a_in  = '0;
  logic [31:0] b_in  = '0;
  logic [31:0] z_hi;
  logic [31:0] z_lo;
  logic        busy;
  logic        done;
  logic        div0;

  int checks   = 0;
  int failures = 0;

  // Results captured by do_op
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_div0;
  logic        r_div0_acc;
  logic        r_busy_acc;
  int          r_lat;
  int          r_width;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .start(start),
    .op   (op),
    .a_in (a_in),
    .b_in (b_in),
    .z_hi (z_hi),
    .z_lo (z_lo),
    .busy (busy),
    .done (done),
    .div0 (div0)
  );

  // Reference: {div0, hi, lo} from plain signed arithmetic
  function automatic logic [64:0] model(input logic o, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 1'b0) begin
      p = sa * sb;
      return {1'b0, p[63:0]};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  // Operand generator biased toward corner values
  function automatic logic [31:0] pick();
    int sel;
    sel = int'($urandom_range(0, 7));
    case (sel)
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'(int'($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from idle, scramble inputs afterwards, record outputs at
  // the first done and how many cycles done stayed high
  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    @(posedge clk); #1;
    r_div0_acc = div0;
    r_busy_acc = busy;
    start = 1'b0;
    op    = 1'($urandom);
    a_in  = $urandom;
    b_in  = $urandom;
    r_lat   = -1;
    r_width = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        r_width++;
        if (r_lat < 0) begin
          r_lat  = k;
          r_hi   = z_hi;
          r_lo   = z_lo;
          r_div0 = div0;
        end
      end
    end
  endtask

  task automatic test_reset;
    #2 clr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (z_hi !== 32'd0) begin failures++; $display("FAIL reset_z_hi got %h expected 0", z_hi); end
    if (z_lo !== 32'd0) begin failures++; $display("FAIL reset_z_lo got %h expected 0", z_lo); end
    if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got %b expected 0", busy); end
    if (done !== 1'b0)  begin failures++; $display("FAIL reset_done got %b expected 0", done); end
    if (div0 !== 1'b0)  begin failures++; $display("FAIL reset_div0 got %b expected 0", div0); end
    // Start on the very first edge with reset released
    clr_n = 1'b1;
    do_op(1'b0, 32'd6, 32'd7);
    checks += 2;
    if (r_lat !== 34) begin failures++; $display("FAIL reset_release_latency got %0d expected 34", r_lat); end
    if ({r_hi, r_lo} !== 64'd42) begin failures++; $display("FAIL reset_release_mul got %h%h expected 42", r_hi, r_lo); end
  endtask

  task automatic test_mul;
    logic [64:0] e;
    logic [31:0] a;
    logic [31:0] b;
    do_op(1'b0, 32'd7, 32'hFFFF_FFFD);
    checks += 5;
    if (r_hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mul_7x-3_hi got %h expected ffffffff", r_hi); end
    if (r_lo !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_7x-3_lo got %h expected ffffffeb", r_lo); end
    if (r_lat !== 34) begin failures++; $display("FAIL mul_latency got %0d expected 34", r_lat); end
    if (r_width !== 1) begin failures++; $display("FAIL done_width got %0d expected 1", r_width); end
    if (r_busy_acc !== 1'b1) begin failures++; $display("FAIL busy_after_accept got %b expected 1", r_busy_acc); end
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000);
    checks++;
    if ({r_hi, r_lo} !== 64'h4000_0000_0000_0000) begin
      failures++; $display("FAIL mul_min_sq got %h_%h expected 40000000_00000000", r_hi, r_lo);
    end
    for (int i = 0; i < 20; i++) begin
      a = pick();
      b = pick();
      e = model(1'b0, a, b);
      do_op(1'b0, a, b);
      checks++;
      if ({r_hi, r_lo} !== e[63:0]) begin
        failures++; $display("FAIL mul_rand a=%h b=%h got %h_%h expected %h", a, b, r_hi, r_lo, e[63:0]);
      end
    end
  endtask

  task automatic test_div;
    logic [64:0] e;
    logic [31:0] a;
    logic [31:0] b;
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    checks += 2;
    if (r_lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_-7/2_q got %h expected fffffffd", r_lo); end
    if (r_hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_-7/2_r got %h expected ffffffff", r_hi); end
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    checks += 2;
    if (r_lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_7/-2_q got %h expected fffffffd", r_lo); end
    if (r_hi !== 32'd1) begin failures++; $display("FAIL div_7/-2_r got %h expected 1", r_hi); end
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    checks += 2;
    if ({r_hi, r_lo} !== {32'd0, 32'h8000_0000}) begin
      failures++; $display("FAIL div_overflow got %h_%h expected 00000000_80000000", r_hi, r_lo);
    end
    if (r_div0 !== 1'b0) begin failures++; $display("FAIL div_overflow_div0 got %b expected 0", r_div0); end
    for (int i = 0; i < 20; i++) begin
      a = pick();
      b = pick();
      e = model(1'b1, a, b);
      do_op(1'b1, a, b);
      checks++;
      if ({r_div0, r_hi, r_lo} !== e) begin
        failures++; $display("FAIL div_rand a=%h b=%h got %b_%h_%h expected %h", a, b, r_div0, r_hi, r_lo, e);
      end
    end
  endtask

  task automatic test_div_zero;
    do_op(1'b1, 32'd100, 32'd0);
    checks += 5;
    if (r_lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_q got %h expected ffffffff", r_lo); end
    if (r_hi !== 32'd100) begin failures++; $display("FAIL div0_r got %h expected 64", r_hi); end
    if (r_div0 !== 1'b1) begin failures++; $display("FAIL div0_flag got %b expected 1", r_div0); end
    if (r_lat !== 34) begin failures++; $display("FAIL div0_latency got %0d expected 34", r_lat); end
    if (div0 !== 1'b1) begin failures++; $display("FAIL div0_hold got %b expected 1", div0); end
    do_op(1'b1, 32'd9, 32'd3);
    checks += 2;
    if (r_div0_acc !== 1'b0) begin failures++; $display("FAIL div0_clear_on_start got %b expected 0", r_div0_acc); end
    if ({r_div0, r_hi, r_lo} !== {1'b0, 32'd0, 32'd3}) begin
      failures++; $display("FAIL div_9/3 got %b_%h_%h expected 0_0_3", r_div0, r_hi, r_lo);
    end
  endtask

  task automatic test_abort;
    logic saw_done;
    do_op(1'b0, 32'h1234_5678, 32'd9);
    checks++;
    if ({r_hi, r_lo} !== {32'd0, 32'hA3D7_0A38}) begin
      failures++; $display("FAIL abort_setup got %h_%h expected 00000000_a3d70a38", r_hi, r_lo);
    end
    start = 1'b1; op = 1'b0; a_in = 32'd5; b_in = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 10) start = 1'b1;
      if (k == 11) start = 1'b0;
      if (k == 19) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_mid got %b expected 1", busy); end
      end
    end
    clr_n = 1'b0;
    #1;
    checks += 5;
    if (z_hi !== 32'd0) begin failures++; $display("FAIL abort_z_hi got %h expected 0", z_hi); end
    if (z_lo !== 32'd0) begin failures++; $display("FAIL abort_z_lo got %h expected 0", z_lo); end
    if (busy !== 1'b0)  begin failures++; $display("FAIL abort_busy got %b expected 0", busy); end
    if (done !== 1'b0)  begin failures++; $display("FAIL abort_done got %b expected 0", done); end
    if (div0 !== 1'b0)  begin failures++; $display("FAIL abort_div0 got %b expected 0", div0); end
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks += 2;
    if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got %b expected 0", saw_done); end
    if (z_lo !== 32'd0) begin failures++; $display("FAIL abort_no_result got %h expected 0", z_lo); end
  endtask

  task automatic test_back_to_back;
    logic [64:0] e;
    logic [64:0] got;
    logic        o;
    logic [31:0] a;
    logic [31:0] b;
    logic        t_ok;
    o = 1'($urandom); a = pick(); b = pick();
    start = 1'b1; op = o; a_in = a; b_in = b;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      e    = model(o, a, b);
      t_ok = 1'b1;
      got  = '0;
      for (int k = 1; k <= 34; k++) begin
        @(posedge clk); #1;
        if (k < 34) begin
          if (done !== 1'b0 || busy !== 1'b1) t_ok = 1'b0;
          op = 1'($urandom); a_in = $urandom; b_in = $urandom;
        end else begin
          if (done !== 1'b1 || busy !== 1'b0) t_ok = 1'b0;
          got = {div0, z_hi, z_lo};
        end
      end
      checks += 2;
      if (t_ok !== 1'b1) begin failures++; $display("FAIL b2b_timing op#%0d busy/done sequence wrong (got 0 expected 1)", i); end
      if (got !== e) begin
        failures++; $display("FAIL b2b_result op#%0d op=%b a=%h b=%h got %h expected %h", i, o, a, b, got, e);
      end
      o = 1'($urandom); a = pick(); b = pick();
      op = o; a_in = a; b_in = b;
      if (i == 999) start = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; the only supported value is 32.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 clr_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  1  0 = MUL, 1 = DIV; sampled with start.
REQ-006 a_in  input  32  operand A (multiplicand or dividend), driven from the Y register.
REQ-007 b_in  input  32  operand B (multiplier or divisor), driven from the bus mux output.
REQ-008 z_hi  output  32  result high word; feeds the ZHI bus source.
REQ-009 z_lo  output  32  result low word; feeds the ZLO bus source.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  single-cycle completion pulse.
REQ-012 div0  output  1  divide-by-zero flag; valid while done is high; held until the next accepted start.

Function
REQ-013 FSM states: IDLE, ITER, FIX, DONE.
REQ-014 Transitions: IDLE->ITER on start; ITER->FIX after 32 iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-015 Operand capture: on the edge where start=1 in IDLE, latch a_in, b_in and op, clear the iteration counter, and clear div0.
REQ-016 Inputs: a_in, b_in and op are ignored after capture; start is ignored while busy=1.
REQ-017 ITER: each of the 32 cycles performs one step (radix-2 Booth for MUL, non-restoring for DIV); the 6-bit counter runs 0..31.
REQ-018 FIX: applies the final remainder restore and the sign correction, then loads z_hi and z_lo on the edge entering DONE.
REQ-019 Latency: if start is accepted at edge N, done is high for exactly the cycle between edges N+34 and N+35.
REQ-020 MUL: {z_hi,z_lo} = full 64-bit two's-complement product a_in*b_in; no overflow is possible.
REQ-021 DIV: z_lo = signed quotient truncated toward zero.
REQ-022 DIV: z_hi = remainder, with the sign of the dividend, satisfying a = q*b + r and |r| < |b|.
REQ-023 DIV with b_in=0: z_lo = 32'hFFFFFFFF, z_hi = a_in, and div0=1.
REQ-024 Divide-by-zero latency: identical to a normal DIV (34 cycles).
REQ-025 DIV of 32'h80000000 by 32'hFFFFFFFF: z_lo = 32'h80000000, z_hi = 0, and div0=0.
REQ-026 z_hi and z_lo change only on the edge entering DONE and otherwise hold their last result.
REQ-027 start asserted during DONE is ignored; a new start is accepted in IDLE one cycle later at the earliest.
REQ-028 Back-to-back throughput: one operation every 35 cycles.

Reset
REQ-029 While clr_n=0, regardless of clk: state=IDLE and counter=0.
REQ-030 While clr_n=0, regardless of clk: z_hi=0, z_lo=0, busy=0, done=0, div0=0.
REQ-031 Reset during ITER or FIX aborts the operation; no partial result is ever visible on z_hi or z_lo.
REQ-032 Reset deassertion takes effect on the first rising edge with clr_n=1; the block is in IDLE and ready for start on that edge.

Structure
REQ-033 Shared CPU package contents: the op encoding constants (MUL=0, DIV=1), the FSM state encoding, and the ITER_COUNT=32 constant.
REQ-034 Sub-modules: none required; the Booth and non-restoring datapaths share one 65-bit accumulator/shift register and one 33-bit adder/subtractor inside this module.
REQ-035 Downstream consumers (ZHI/ZLO bus sources) read z_hi and z_lo directly; there is no additional output register.

Verification
REQ-036 MUL a=7, b=-3 -> at done: z_hi=32'hFFFFFFFF, z_lo=32'hFFFFFFEB, with done exactly 34 cycles after start.
REQ-037 MUL a=32'h80000000, b=32'h80000000 -> z_hi=32'h40000000, z_lo=0.
REQ-038 DIV a=-7, b=2 -> z_lo=32'hFFFFFFFD (-3), z_hi=32'hFFFFFFFF (-1); DIV a=7, b=-2 -> z_lo=-3, z_hi=1.
REQ-039 DIV a=100, b=0 -> z_lo=32'hFFFFFFFF, z_hi=100, div0=1 during done; div0 clears at the next accepted start.
REQ-040 Start MUL, pulse start again at cycle 10, then assert clr_n=0 at cycle 20 -> second start ignored; all outputs read 0 immediately; no done pulse follows.
REQ-041 Random signed a/b, 1000 back-to-back ops checked against a reference model -> results match; busy and done timing hold per REQ-019 and REQ-028.
